add_sub_seq: RTL and testbench

Sequencing controller that sits directly upstream of the 4-bit combinational `add_sub` unit and consumes its result. It accepts accumulate commands over a valid/ready handshake and drives the adder's `m`/`a`/`b` inputs from an internal 4-bit accumulator and a latched operand. It captures `s`/`cout` one cycle later, tracks the sign that `add_sub` discards on subtraction, and presents the registered result over a second valid/ready handshake.

---
 rtl/add_sub_seq.sv | 115 +++++++++++
 tb/tb_add_sub_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq.sv
// Sequencer for the 4-bit add_sub unit: accepts accumulate commands,
// drives the adder for one cycle and returns the registered result.
module add_sub_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [3:0] in_data,
  output logic       as_m,
  output logic [3:0] as_a,
  output logic [3:0] as_b,
  input  logic [3:0] as_s,
  input  logic       as_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_acc,
  output logic       out_carry,
  output logic       out_neg,
  output logic [7:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t     state_q;
  logic [1:0] op_q;
  logic [3:0] data_q;
  logic [3:0] acc_q;
  logic       carry_q;
  logic       neg_q;
  logic [7:0] count_q;

  logic [3:0] acc_d;
  logic       carry_d;
  logic       neg_d;

  logic exec;
  assign exec = (state_q == S_EXEC);

  // Adder inputs are quiet outside EXEC
  assign as_m = exec && (op_q == OP_SUB);
  assign as_a = exec ? acc_q  : 4'd0;
  assign as_b = exec ? data_q : 4'd0;

  always_comb begin
    acc_d   = acc_q;
    carry_d = 1'b0;
    neg_d   = 1'b0;
    unique case (op_q)
      OP_LOAD:  acc_d = data_q;
      OP_ADD: begin
        acc_d   = as_s;
        carry_d = as_cout;
      end
      // add_sub returns the magnitude; the sign comes from our own compare
      OP_SUB: begin
        acc_d = as_s;
        neg_d = (acc_q < data_q);
      end
      OP_CLEAR: acc_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      data_q  <= 4'd0;
      acc_q   <= 4'd0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            data_q  <= in_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          neg_q   <= neg_d;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            count_q <= count_q + 8'd1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign out_acc   = acc_q;
  assign out_carry = carry_q;
  assign out_neg   = neg_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed bench for add_sub_seq with a behavioural add_sub unit
// attached to the adder ports.
module tb_add_sub_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic       as_m;
  logic [3:0] as_a;
  logic [3:0] as_b;
  logic [3:0] as_s;
  logic       as_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_acc;
  logic       out_carry;
  logic       out_neg;
  logic [7:0] out_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  add_sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .as_m      (as_m),
    .as_a      (as_a),
    .as_b      (as_b),
    .as_s      (as_s),
    .as_cout   (as_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_carry (out_carry),
    .out_neg   (out_neg),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural add_sub: sum mod 16 with carry, or |a-b| with cout=0
  always_comb begin
    as_s    = 4'd0;
    as_cout = 1'b0;
    if (as_m) begin
      as_s = (as_a >= as_b) ? as_a - as_b : as_b - as_a;
    end else begin
      {as_cout, as_s} = {1'b0, as_a} + {1'b0, as_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 in IDLE, ends at posedge+1 back in IDLE
  task automatic cmd(input logic [1:0] op, input logic [3:0] d,
                     input logic e_m, input logic [3:0] e_a,
                     input logic [3:0] e_b, input logic [3:0] e_acc,
                     input logic e_c, input logic e_n);
    chk("idle_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("exec_ready", in_ready, 0);
    chk("exec_valid", out_valid, 0);
    chk("exec_m", as_m, e_m);
    chk("exec_a", as_a, e_a);
    chk("exec_b", as_b, e_b);
    @(posedge clk);
    @(negedge clk);
    chk("resp_valid", out_valid, 1);
    chk("resp_acc", out_acc, e_acc);
    chk("resp_carry", out_carry, e_c);
    chk("resp_neg", out_neg, e_n);
    chk("resp_m", as_m, 0);
    @(posedge clk); #1;
    exp_cnt = (exp_cnt + 1) % 256;
    chk("post_ready", in_ready, 1);
    chk("post_count", out_count, exp_cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_count", out_count, 0);
    chk("rst_as", {as_m, as_a, as_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LOAD 9, ADD 5
    cmd(2'b00, 4'd9, 0, 4'd0, 4'd9, 4'd9, 0, 0);
    cmd(2'b01, 4'd5, 0, 4'd9, 4'd5, 4'd14, 0, 0);
    chk("count_two", out_count, 2);

    // LOAD 12, ADD 7 wraps
    cmd(2'b00, 4'd12, 0, 4'd14, 4'd12, 4'd12, 0, 0);
    cmd(2'b01, 4'd7, 0, 4'd12, 4'd7, 4'd3, 1, 0);

    // LOAD 3, SUB 9 negative, SUB 6 zero
    cmd(2'b00, 4'd3, 0, 4'd3, 4'd3, 4'd3, 0, 0);
    cmd(2'b10, 4'd9, 1, 4'd3, 4'd9, 4'd6, 0, 1);
    cmd(2'b10, 4'd6, 1, 4'd6, 4'd6, 4'd0, 0, 0);

    // LOAD 5 then CLEAR under backpressure
    cmd(2'b00, 4'd5, 0, 4'd0, 4'd5, 4'd5, 0, 0);
    in_valid  = 1'b1;
    in_op     = 2'b11;
    in_data   = 4'd0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_op   = 2'b00;
    in_data = 4'd7;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_acc", out_acc, 0);
      chk("bp_ready", in_ready, 0);
      chk("bp_count", out_count, exp_cnt);
      @(posedge clk);
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1;
    chk("bp_done_ready", in_ready, 1);
    chk("bp_done_count", out_count, exp_cnt);
    chk("bp_done_acc", out_acc, 0);

    // Fresh reset, then 256 back-to-back ADD 1
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_op     = 2'b01;
    in_data   = 4'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk("b2b_ready", in_ready, 1);
      @(posedge clk);
      @(posedge clk); #1;
      chk("b2b_acc", out_acc, (i + 1) % 16);
      chk("b2b_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_count_wrap", out_count, 0);
    chk("b2b_idle", in_ready, 1);

    // LOAD 10, then reset during EXEC of ADD 4
    cmd(2'b00, 4'd10, 0, 4'd0, 4'd10, 4'd10, 0, 0);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_a", as_a, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", out_acc, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_count", out_count, 0);
    chk("arst_as", {as_m, as_a, as_b}, 0);
    chk("arst_flags", {out_carry, out_neg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", in_ready, 1);
    chk("rel_count", out_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
